// File: rtl/lcd_timing_pkg.sv
// ---------------------------------------------------------------------------
// lcd_timing_pkg
// Shared timing constants, PPU mode encoding and STAT (FF41) bit positions
// used by the LCD line timer and its STAT interrupt sub-block.
// ---------------------------------------------------------------------------
package lcd_timing_pkg;

    // Scan timing, in dot clocks and lines.
    localparam int DOTS_PER_LINE   = 456;
    localparam int LINES_PER_FRAME = 154;
    localparam int VBLANK_LINE     = 144;
    localparam int OAM_DOTS        = 80;
    localparam int XFER_DOTS       = 172;

    // PPU mode as reported in STAT[1:0].
    typedef enum logic [1:0] {
        HBLANK = 2'd0,
        VBLANK = 2'd1,
        OAM    = 2'd2,
        XFER   = 2'd3
    } ppu_mode_t;

    // Bit positions within the FF41 byte.
    localparam int STAT_BIT_ONE  = 7;  // always reads 1
    localparam int STAT_IE_LYC   = 6;
    localparam int STAT_IE_MODE2 = 5;
    localparam int STAT_IE_MODE1 = 4;
    localparam int STAT_IE_MODE0 = 3;
    localparam int STAT_LYC_EQ   = 2;
    localparam int STAT_MODE_HI  = 1;
    localparam int STAT_MODE_LO  = 0;

    // Bit positions within the 4-bit interrupt-enable register.
    localparam int IE_LYC   = 3;
    localparam int IE_MODE2 = 2;
    localparam int IE_MODE1 = 1;
    localparam int IE_MODE0 = 0;

endpackage : lcd_timing_pkg

// File: rtl/lcd_stat_irq.sv
// ---------------------------------------------------------------------------
// lcd_stat_irq
// Holds the STAT interrupt-enable bits, forms the combined STAT interrupt
// line and issues a one-cycle request on each rising edge of that line.
//
// Ports:
//   clk, reset   dot clock, synchronous active-high reset
//   lcd_en       LCDC.7; while low the line is forced low and no request fires
//   stat_wr      one-cycle FF41 write strobe
//   ie_wdata     new enable bits {lyc, mode2, mode1, mode0}
//   lyc_eq       LY==LYC coincidence (already gated by lcd_en)
//   mode         current PPU mode
//   ie           enable bits, for the STAT readback
//   stat_irq     registered one-cycle STAT interrupt request
// ---------------------------------------------------------------------------
module lcd_stat_irq
    import lcd_timing_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_en,
    input  logic       stat_wr,
    input  logic [3:0] ie_wdata,
    input  logic       lyc_eq,
    input  ppu_mode_t  mode,
    output logic [3:0] ie,
    output logic       stat_irq
);

    logic [3:0] ie_q, ie_d;
    logic       line_q, line_d;
    logic       stat_irq_q, stat_irq_d;
    logic       line_c;

    always_comb begin
        line_c = (ie_q[IE_LYC]   & lyc_eq)
               | (ie_q[IE_MODE2] & (mode == OAM))
               | (ie_q[IE_MODE1] & (mode == VBLANK))
               | (ie_q[IE_MODE0] & (mode == HBLANK));

        // Enables stay writable while the LCD is off.
        ie_d = stat_wr ? ie_wdata : ie_q;

        // Disabled mode reads as HBlank, so gate explicitly: with the LCD off
        // the line must read low and re-enabling must see a fresh rising edge.
        line_d     = lcd_en & line_c;
        // Only a low-to-high transition requests; sources that overlap while
        // the line is already high are absorbed.
        stat_irq_d = lcd_en & line_c & ~line_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q       <= '0;
            line_q     <= 1'b0;
            stat_irq_q <= 1'b0;
        end else begin
            ie_q       <= ie_d;
            line_q     <= line_d;
            stat_irq_q <= stat_irq_d;
        end
    end

    assign ie       = ie_q;
    assign stat_irq = stat_irq_q;

endmodule : lcd_stat_irq

// File: rtl/lcd_line_timer.sv
// ---------------------------------------------------------------------------
// lcd_line_timer
// Dot/line sequencer for the LCD. Counts dots within a line and lines within
// a frame, drives LY, decodes the PPU mode, computes LY==LYC, assembles the
// STAT readback and raises the VBlank and STAT interrupt requests.
//
// Ports:
//   clk          dot clock (4.194304 MHz)
//   reset        synchronous active-high reset
//   lcd_en       LCDC bit 7
//   lyc          LYC compare value
//   stat_wr      one-cycle FF41 write strobe; d_in[6:3] land in the enables
//   d_in         CPU write data
//   v            current LY
//   mode         PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 transfer)
//   lyc_eq       LY==LYC, combinational
//   stat_q       FF41 readback {1, ie[3:0], lyc_eq, mode}
//   line_start   combinational pulse at dot 0 of every line
//   vblank_irq   registered one-cycle pulse after LY=144, dot 0
//   stat_irq     registered one-cycle pulse on each STAT line rising edge
// ---------------------------------------------------------------------------
module lcd_line_timer #(
    parameter int DOTS_PER_LINE   = lcd_timing_pkg::DOTS_PER_LINE,
    parameter int LINES_PER_FRAME = lcd_timing_pkg::LINES_PER_FRAME,
    parameter int VBLANK_LINE     = lcd_timing_pkg::VBLANK_LINE,
    parameter int OAM_DOTS        = lcd_timing_pkg::OAM_DOTS,
    parameter int XFER_DOTS       = lcd_timing_pkg::XFER_DOTS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_en,
    input  logic [7:0] lyc,
    input  logic       stat_wr,
    input  logic [7:0] d_in,
    output logic [7:0] v,
    output logic [1:0] mode,
    output logic       lyc_eq,
    output logic [7:0] stat_q,
    output logic       line_start,
    output logic       vblank_irq,
    output logic       stat_irq
);

    import lcd_timing_pkg::*;

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
    localparam logic [8:0] XFER_END  = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] LY_LAST   = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0] LY_VBLANK = 8'(VBLANK_LINE);

    logic [8:0] dot_q, dot_d;
    logic [7:0] ly_q, ly_d;
    logic       vblank_irq_q, vblank_irq_d;
    ppu_mode_t  mode_c;
    logic       lyc_eq_c;
    logic [3:0] ie;

    // Only d_in[6:3] are writable in FF41; the remaining bits are dropped.
    logic       unused_d_in;
    assign unused_d_in = ^{d_in[7], d_in[2:0]};

    // Dot / line counters. Turning the LCD off parks both at zero so that
    // re-enabling starts a fresh frame at line 0, dot 0 (mode 2).
    always_comb begin
        dot_d = dot_q;
        ly_d  = ly_q;
        if (!lcd_en) begin
            dot_d = '0;
            ly_d  = '0;
        end else if (dot_q == DOT_LAST) begin
            dot_d = '0;
            ly_d  = (ly_q == LY_LAST) ? '0 : ly_q + 8'd1;
        end else begin
            dot_d = dot_q + 9'd1;
        end
    end

    // Mode decode straight from the counters; VBlank lines override the
    // per-dot split.
    always_comb begin
        mode_c = HBLANK;
        if (lcd_en) begin
            if (ly_q >= LY_VBLANK) begin
                mode_c = VBLANK;
            end else if (dot_q < OAM_END) begin
                mode_c = OAM;
            end else if (dot_q < XFER_END) begin
                mode_c = XFER;
            end else begin
                mode_c = HBLANK;
            end
        end
    end

    always_comb begin
        lyc_eq_c     = lcd_en & (ly_q == lyc);
        vblank_irq_d = lcd_en & (ly_q == LY_VBLANK) & (dot_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dot_q        <= '0;
            ly_q         <= '0;
            vblank_irq_q <= 1'b0;
        end else begin
            dot_q        <= dot_d;
            ly_q         <= ly_d;
            vblank_irq_q <= vblank_irq_d;
        end
    end

    lcd_stat_irq u_stat_irq (
        .clk      (clk),
        .reset    (reset),
        .lcd_en   (lcd_en),
        .stat_wr  (stat_wr),
        .ie_wdata (d_in[STAT_IE_LYC:STAT_IE_MODE0]),
        .lyc_eq   (lyc_eq_c),
        .mode     (mode_c),
        .ie       (ie),
        .stat_irq (stat_irq)
    );

    assign v          = ly_q;
    assign mode       = mode_c;
    assign lyc_eq     = lyc_eq_c;
    assign stat_q     = {1'b1, ie, lyc_eq_c, mode_c};
    assign line_start = lcd_en & (dot_q == '0);
    assign vblank_irq = vblank_irq_q;

endmodule : lcd_line_timer

// File: tb/tb_lcd_line_timer.sv
// ---------------------------------------------------------------------------
// tb_lcd_line_timer
// Directed bench for lcd_line_timer. Scenarios run back to back on one
// timeline; a per-cycle monitor in step() tallies line_start and vblank_irq
// from the moment a frame is started from reset.
// ---------------------------------------------------------------------------
module tb_lcd_line_timer;

    localparam int LINE  = 456;
    localparam int FRAME = 70224;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_en;
    logic [7:0] lyc;
    logic       stat_wr;
    logic [7:0] d_in;
    logic [7:0] v;
    logic [1:0] mode;
    logic       lyc_eq;
    logic [7:0] stat_q;
    logic       line_start;
    logic       vblank_irq;
    logic       stat_irq;

    int checks   = 0;
    int failures = 0;

    // Frame monitor state: frame_cyc is the dot index of the current state
    // counted from the frame start.
    int frame_cyc = 0;
    bit mon_on    = 1'b0;
    int ls_cnt    = 0;
    int vb_cnt    = 0;
    int vb_cyc    = -1;

    lcd_line_timer dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_en     (lcd_en),
        .lyc        (lyc),
        .stat_wr    (stat_wr),
        .d_in       (d_in),
        .v          (v),
        .mode       (mode),
        .lyc_eq     (lyc_eq),
        .stat_q     (stat_q),
        .line_start (line_start),
        .vblank_irq (vblank_irq),
        .stat_irq   (stat_irq)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        frame_cyc++;
        if (mon_on) begin
            if (frame_cyc < FRAME && line_start) ls_cnt++;
            if (vblank_irq) begin
                vb_cnt++;
                vb_cyc = frame_cyc;
            end
        end
    endtask

    task automatic frame_begin();
        frame_cyc = 0;
        mon_on    = 1'b1;
        ls_cnt    = line_start ? 1 : 0;
        vb_cnt    = 0;
        vb_cyc    = -1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; lcd_en = 1'b0; lyc = 8'h05; stat_wr = 1'b0; d_in = 8'h00;
        repeat (2) step();
        checks++; if (v !== 8'd0) begin failures++; $display("FAIL rst_v got=%0d exp=0", v); end
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL rst_mode_off got=%0d exp=0", mode); end
        checks++; if (stat_q !== 8'h80) begin failures++; $display("FAIL rst_stat_off got=%02h exp=80", stat_q); end
        checks++; if (stat_irq !== 1'b0) begin failures++; $display("FAIL rst_stat_irq got=%b exp=0", stat_irq); end
        checks++; if (vblank_irq !== 1'b0) begin failures++; $display("FAIL rst_vblank_irq got=%b exp=0", vblank_irq); end
        checks++; if (line_start !== 1'b0) begin failures++; $display("FAIL rst_line_start_off got=%b exp=0", line_start); end
        lcd_en = 1'b1;
        #1;
        checks++; if (mode !== 2'd2) begin failures++; $display("FAIL rst_mode_on got=%0d exp=2", mode); end
        checks++; if (stat_q !== 8'h82) begin failures++; $display("FAIL rst_stat_on got=%02h exp=82", stat_q); end
        checks++; if (line_start !== 1'b1) begin failures++; $display("FAIL rst_line_start_on got=%b exp=1", line_start); end
        lyc = 8'h00;
        #1;
        checks++; if (lyc_eq !== 1'b1) begin failures++; $display("FAIL rst_lyc_eq got=%b exp=1", lyc_eq); end
        checks++; if (stat_q !== 8'h86) begin failures++; $display("FAIL rst_stat_lyc got=%02h exp=86", stat_q); end
        lyc = 8'h05;
        step();
        reset = 1'b0;
        checks++; if (v !== 8'd0) begin failures++; $display("FAIL rst_hold_v got=%0d exp=0", v); end
    endtask

    // LCD off at LY 10 dot 200 with mode-2 interrupt enabled, then back on.
    task automatic test_disable();
        stat_wr = 1'b1; d_in = 8'h20;
        step();
        stat_wr = 1'b0;
        repeat (10 * LINE + 200 - 1) step();
        checks++; if (v !== 8'd10) begin failures++; $display("FAIL dis_pre_v got=%0d exp=10", v); end
        checks++; if (mode !== 2'd3) begin failures++; $display("FAIL dis_pre_mode got=%0d exp=3", mode); end
        lcd_en = 1'b0;
        #1;
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL dis_mode_now got=%0d exp=0", mode); end
        step();
        checks++; if (v !== 8'd0) begin failures++; $display("FAIL dis_v got=%0d exp=0", v); end
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL dis_mode got=%0d exp=0", mode); end
        checks++; if (stat_q[2:0] !== 3'd0) begin failures++; $display("FAIL dis_stat_lo got=%0d exp=0", stat_q[2:0]); end
        checks++; if (stat_q !== 8'hA0) begin failures++; $display("FAIL dis_stat_ie got=%02h exp=A0", stat_q); end
        checks++; if (line_start !== 1'b0) begin failures++; $display("FAIL dis_line_start got=%b exp=0", line_start); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (stat_irq !== 1'b0) begin failures++; $display("FAIL dis_no_irq got=%b exp=0", stat_irq); end
            step();
            checks++; if (v !== 8'd0) begin failures++; $display("FAIL dis_hold_v got=%0d exp=0", v); end
        end
        lcd_en = 1'b1;
        #1;
        checks++; if (mode !== 2'd2) begin failures++; $display("FAIL ren_mode got=%0d exp=2", mode); end
        checks++; if (v !== 8'd0) begin failures++; $display("FAIL ren_v got=%0d exp=0", v); end
        step();
        checks++; if (stat_irq !== 1'b1) begin failures++; $display("FAIL ren_irq got=%b exp=1", stat_irq); end
        step();
        checks++; if (stat_irq !== 1'b0) begin failures++; $display("FAIL ren_irq_end got=%b exp=0", stat_irq); end
    endtask

    // Reset lands on LY 4 dot 252, the cycle a mode-0 STAT request would be
    // registered, together with an FF41 write: reset must win on all counts.
    task automatic test_reset_mid_frame();
        stat_wr = 1'b1; d_in = 8'h78; lyc = 8'h03;
        step();
        stat_wr = 1'b0;
        repeat (4 * LINE + 252 - 3) step();
        checks++; if (v !== 8'd4) begin failures++; $display("FAIL rmid_pre_v got=%0d exp=4", v); end
        checks++; if (stat_q !== 8'hF8) begin failures++; $display("FAIL rmid_pre_stat got=%02h exp=F8", stat_q); end
        reset = 1'b1; stat_wr = 1'b1; d_in = 8'h78;
        step();
        checks++; if (v !== 8'd0) begin failures++; $display("FAIL rmid_v got=%0d exp=0", v); end
        checks++; if (stat_q !== 8'h82) begin failures++; $display("FAIL rmid_stat got=%02h exp=82", stat_q); end
        checks++; if (stat_irq !== 1'b0) begin failures++; $display("FAIL rmid_stat_irq got=%b exp=0", stat_irq); end
        checks++; if (vblank_irq !== 1'b0) begin failures++; $display("FAIL rmid_vblank_irq got=%b exp=0", vblank_irq); end
        checks++; if (line_start !== 1'b1) begin failures++; $display("FAIL rmid_line_start got=%b exp=1", line_start); end
        reset = 1'b0; stat_wr = 1'b0; d_in = 8'h00;
    endtask

    task automatic test_line_modes();
        logic [1:0] exp_mode;
        for (int d = 0; d < LINE; d++) begin
            exp_mode = (d < 80) ? 2'd2 : (d < 252) ? 2'd3 : 2'd0;
            checks++;
            if (mode !== exp_mode) begin
                failures++; $display("FAIL line_mode dot=%0d got=%0d exp=%0d", d, mode, exp_mode);
            end
            step();
        end
        checks++; if (v !== 8'd1) begin failures++; $display("FAIL line_v_step got=%0d exp=1", v); end
        checks++; if (line_start !== 1'b1) begin failures++; $display("FAIL line_start_l1 got=%b exp=1", line_start); end
        checks++; if (mode !== 2'd2) begin failures++; $display("FAIL line_mode_l1 got=%0d exp=2", mode); end
    endtask

    // LYC interrupt only: one request on entering LY 10.
    task automatic test_lyc_irq();
        int pulses = 0;
        int at     = -1;
        lyc = 8'd10; stat_wr = 1'b1; d_in = 8'h40;
        step();
        stat_wr = 1'b0;
        while (frame_cyc < 11 * LINE) begin
            if (stat_irq) begin pulses++; at = frame_cyc; end
            if (frame_cyc >= 10 * LINE && frame_cyc < 10 * LINE + 80) begin
                checks++; if (stat_q !== 8'hC6) begin failures++; $display("FAIL lyc_stat_m2 cyc=%0d got=%02h exp=C6", frame_cyc, stat_q); end
            end
            if (frame_cyc == 10 * LINE + 100) begin
                checks++; if (stat_q !== 8'hC7) begin failures++; $display("FAIL lyc_stat_m3 got=%02h exp=C7", stat_q); end
            end
            step();
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL lyc_pulse_count got=%0d exp=1", pulses); end
        checks++; if (at != 10 * LINE + 1) begin failures++; $display("FAIL lyc_pulse_time got=%0d exp=%0d", at, 10 * LINE + 1); end
    endtask

    // Mode-0 + mode-2 + LYC enables written mid-transfer on LY 11 with
    // LYC=12. The line rises at dot 252 of LY 11 and then stays high across
    // HBlank -> OAM and the LY 12 coincidence, so exactly one request.
    task automatic test_stat_blocking();
        int pulses = 0;
        int at     = -1;
        while (frame_cyc < 11 * LINE + 100) step();
        stat_wr = 1'b1; d_in = 8'h68; lyc = 8'd12;
        step();
        stat_wr = 1'b0;
        while (frame_cyc <= 12 * LINE + 80) begin
            if (stat_irq) begin pulses++; at = frame_cyc; end
            if (frame_cyc == 12 * LINE) begin
                checks++; if (stat_q !== 8'hEE) begin failures++; $display("FAIL blk_stat got=%02h exp=EE", stat_q); end
                checks++; if (lyc_eq !== 1'b1) begin failures++; $display("FAIL blk_lyc_eq got=%b exp=1", lyc_eq); end
            end
            step();
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL blk_pulse_count got=%0d exp=1", pulses); end
        checks++; if (at != 11 * LINE + 253) begin failures++; $display("FAIL blk_pulse_time got=%0d exp=%0d", at, 11 * LINE + 253); end
    endtask

    task automatic test_frame();
        while (frame_cyc < FRAME) begin
            if (frame_cyc == 144 * LINE) begin
                checks++; if (v !== 8'd144) begin failures++; $display("FAIL frm_v144 got=%0d exp=144", v); end
                checks++; if (mode !== 2'd1) begin failures++; $display("FAIL frm_mode_vbl got=%0d exp=1", mode); end
            end
            if (frame_cyc == FRAME - 1) begin
                checks++; if (v !== 8'd153) begin failures++; $display("FAIL frm_v153 got=%0d exp=153", v); end
            end
            step();
        end
        checks++; if (v !== 8'd0) begin failures++; $display("FAIL frm_wrap_v got=%0d exp=0", v); end
        checks++; if (mode !== 2'd2) begin failures++; $display("FAIL frm_wrap_mode got=%0d exp=2", mode); end
        checks++; if (vb_cnt != 1) begin failures++; $display("FAIL frm_vblank_count got=%0d exp=1", vb_cnt); end
        checks++; if (vb_cyc != 144 * LINE + 1) begin failures++; $display("FAIL frm_vblank_time got=%0d exp=%0d", vb_cyc, 144 * LINE + 1); end
        checks++; if (ls_cnt != 154) begin failures++; $display("FAIL frm_line_start_count got=%0d exp=154", ls_cnt); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1; lcd_en = 1'b0; lyc = 8'h00; stat_wr = 1'b0; d_in = 8'h00;
        test_reset();
        test_disable();
        test_reset_mid_frame();
        frame_begin();
        test_line_modes();
        test_lyc_irq();
        test_stat_blocking();
        test_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_lcd_line_timer
